// File: rtl/weight_update.sv
// rtl/weight_update.sv - Gradient-descent weight register bank, one saturated weight update per cycle.
// Holds the neuron weights and rewrites them as w[i] = sat(w[i] - ((delta*x[i]) >>> lr_shift)).
module weight_update #(
  parameter int num_inputs = 2,
  parameter int bit_length = 4,
  parameter int lr_shift   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid,
  input  logic [num_inputs*bit_length-1:0] load_weights,
  input  logic                             upd_valid,
  output logic                             upd_ready,
  input  logic [bit_length-1:0]            delta,
  input  logic [num_inputs*bit_length-1:0] inputs,
  output logic [num_inputs*bit_length-1:0] weights,
  output logic                             busy,
  output logic                             done
);

  localparam int N  = num_inputs;
  localparam int B  = bit_length;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0]       LAST_IDX = IW'(N - 1);
  localparam logic signed [2*B:0] W_MAX    = {{(B + 2){1'b0}}, {(B - 1){1'b1}}};
  localparam logic signed [2*B:0] W_MIN    = {{(B + 2){1'b1}}, {(B - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic signed [B-1:0]       w_q [N];
  logic signed [B-1:0]       x_q [N];
  logic signed [B-1:0]       delta_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [B-1:0]       w_sel;
  logic signed [B-1:0]       x_sel;
  logic signed [2*B-1:0]     prod;
  logic signed [2*B-1:0]     step;
  logic signed [2*B:0]       diff;
  logic signed [B-1:0]       w_d;

  assign upd_ready = (state_q == IDLE) && !load_valid;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      weights[i*B +: B] = w_q[i];
    end
  end

  // Datapath for the weight selected by idx, working on the operands latched at accept.
  always_comb begin
    w_sel = w_q[idx_q];
    x_sel = x_q[idx_q];
    prod  = delta_q * x_sel;
    step  = prod >>> lr_shift;
    diff  = {{(B + 1){w_sel[B-1]}}, w_sel} - {step[2*B-1], step};
    if (diff > W_MAX) begin
      w_d = W_MAX[B-1:0];
    end else if (diff < W_MIN) begin
      w_d = W_MIN[B-1:0];
    end else begin
      w_d = diff[B-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      delta_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            for (int i = 0; i < N; i++) begin
              w_q[i] <= load_weights[i*B +: B];
            end
          end else if (upd_valid) begin
            delta_q <= delta;
            for (int i = 0; i < N; i++) begin
              x_q[i] <= inputs[i*B +: B];
            end
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          w_q[idx_q] <= w_d;
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// tb/tb_weight_update.sv - Scoreboard bench for weight_update with directed hand-computed vectors.
module tb_weight_update;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_weights;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] delta;
  logic [7:0] inputs;
  logic [7:0] weights;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];

  weight_update #(.num_inputs(2), .bit_length(4), .lr_shift(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_weights(load_weights),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .delta(delta), .inputs(inputs),
    .weights(weights), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected final weight vector on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("done_weights", weights, exp_q.pop_front());
        end
      end
      if (busy) chk("ready_while_busy", upd_ready, 1'b0);
      if (upd_valid && upd_ready) acc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] w);
    load_valid = 1'b1;
    load_weights = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_update(input logic [3:0] d, input logic [7:0] x, input logic [7:0] expw);
    exp_q.push_back(expw);
    delta = d;
    inputs = x;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_weights = 8'h00;
    upd_valid = 1'b0;
    delta = 4'h0;
    inputs = 8'h00;
    #1;
    chk("rst_weights", weights, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", upd_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // Basic step: w=(3,-2), delta=2, x=(4,-3) -> (1,0)
    do_load(8'hE3);
    chk("load_visible", weights, 8'hE3);
    exp_q.push_back(8'h01);
    delta = 4'h2;
    inputs = 8'hD4;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    chk("accept_busy", busy, 1'b1);
    step();
    chk("basic_w0_first", weights, 8'hE1);
    step();
    chk("basic_w1_second", weights, 8'h01);
    chk("basic_done_cycle", done, 1'b1);
    wait_idle();

    // Saturation both directions
    do_load(8'h07);
    do_update(4'h8, 8'h07, 8'h07);
    do_load(8'h18);
    do_update(4'h7, 8'hF7, 8'h38);

    // Handshake: upd_valid held high, two accepts 4 cycles apart
    do_load(8'hB5);
    acc_q.delete();
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'hD3);
    delta = 4'h1;
    inputs = 8'hC4;
    upd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    upd_valid = 1'b0;
    wait_idle();
    chk("accept_count", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("accept_spacing", acc_q[1] - acc_q[0], 4);

    // Load priority in IDLE
    load_valid = 1'b1;
    load_weights = 8'h22;
    upd_valid = 1'b1;
    #1;
    chk("load_prio_ready", upd_ready, 1'b0);
    step();
    load_valid = 1'b0;
    upd_valid = 1'b0;
    chk("load_prio_weights", weights, 8'h22);
    chk("load_prio_busy", busy, 1'b0);

    // Load ignored during UPDATE: delta=-1, x=(4,4) -> (3,3)
    exp_q.push_back(8'h33);
    delta = 4'hF;
    inputs = 8'h44;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    load_valid = 1'b1;
    load_weights = 8'h77;
    wait_idle();
    load_valid = 1'b0;
    chk("load_ignored", weights, 8'h33);

    // Operand latching: change operands right after accept
    exp_q.push_back(8'h60);
    delta = 4'h3;
    inputs = 8'hC4;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    delta = 4'h8;
    inputs = 8'h77;
    wait_idle();

    // Reset in the middle of an update
    do_load(8'h11);
    delta = 4'h1;
    inputs = 8'h44;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_weights", weights, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ready", upd_ready, 1'b1);
    #3;
    rst_n = 1'b1;
    repeat (6) step();
    chk("postrst_weights", weights, 8'h00);
    chk("postrst_busy", busy, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_update.md
# weight_update

Backward-pass companion to the weighted-sum neuron in the FPGA cores: holds a neuron's weight vector and applies a gradient-descent step `w[i] <= sat(w[i] - ((delta * x[i]) >>> lr_shift))`, one weight per cycle. It drives the `weights` bus consumed by the forward weighted-sum block. An update is accepted over a valid/ready handshake, and `done` pulses when the whole vector has been rewritten.

## Interface
- `num_inputs`, default 2: number of weights, 1 or more.
- `bit_length`, default 4: width of each weight, input and delta, two's-complement signed, 2 or more.
- `lr_shift`, default 2: learning-rate shift, an arithmetic right shift of the product, 0 to 2*bit_length-1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  load `load_weights` into the weight registers.
- `load_weights`  in  num_inputs*bit_length  initial weights; weight i is at `[i*bit_length +: bit_length]`.
- `upd_valid`  in  1  update request.
- `upd_ready`  out  1  block can accept an update.
- `delta`  in  bit_length  signed error term.
- `inputs`  in  num_inputs*bit_length  signed activations x[i], same packing as the weights.
- `weights`  out  num_inputs*bit_length  current weight registers.
- `busy`  out  1  an update is in progress.
- `done`  out  1  one-cycle pulse after the last weight of an update is written.

## Operation
- States are IDLE, UPDATE and DONE. The block also has an index counter `idx` of width clog2(num_inputs), minimum 1 bit.
- IDLE:
  - If `load_valid` is high, all weights take `load_weights` at the next edge.
  - `upd_ready = (state==IDLE) && !load_valid`. A load has priority over an update in the same cycle.
  - On `upd_valid && upd_ready`, the block latches `delta` and `inputs` into internal registers, clears `idx`, and moves to UPDATE.
- UPDATE: each cycle the block writes weight `idx` from the latched operands and increments `idx`. When `idx == num_inputs-1`, the write still happens and the state moves to DONE.
- DONE: `done=1` for this single cycle, then the state returns to IDLE.
- `load_valid` is ignored outside IDLE. `delta` and `inputs` may change freely after acceptance.
- Arithmetic for each step:
  - p = delta*x[i], signed, 2*bit_length bits.
  - step = p >>> lr_shift, arithmetic shift, rounds toward minus infinity.
  - diff = w[i] - step, computed in 2*bit_length+1 bits.
  - w[i] takes diff saturated to [-2^(bit_length-1), 2^(bit_length-1)-1].
- Only the weight selected by `idx` changes in a given cycle. All other weights hold.
- `busy = (state != IDLE)`.

## Timing
- Reset, asynchronous, while `rst_n`=0:
  - state is IDLE, `idx`=0, all weights are 0 and the latched operands are 0.
  - Outputs: `upd_ready`=1 (if `load_valid`=0), `busy`=0, `done`=0, `weights`=0.
- Reset asserted mid-update aborts the update immediately. Weights return to 0 and no `done` pulse is issued.
- Suppose acceptance happens at edge E:
  - Weight i shows its new value after edge E+1+i.
  - `done` is high during the cycle after edge E+num_inputs.
  - `upd_ready` returns high after edge E+num_inputs+1.
  - Total occupancy is num_inputs+2 cycles per update, so the next acceptance can occur at edge E+num_inputs+2 at the earliest.
- A load at edge L is visible on `weights` after edge L.
- `upd_ready` is combinational from state and `load_valid`. All other outputs come directly from registers.
- With num_inputs=1, the block spends one UPDATE cycle and then goes to DONE.

## Test plan
All scenarios use the defaults: num_inputs=2, bit_length=4, lr_shift=2.
- **Reset:** assert `rst_n`=0 mid-UPDATE. Required: `weights`=0, `busy`=0, `done`=0 and `upd_ready`=1 asynchronously, with no `done` after release.
- **Basic step:**
  - Stimulus: load w0=3, w1=-2; update with delta=2, x0=4, x1=-3.
  - Required: w0=1 one cycle after accept (p=8, step=2); w1=0 one cycle later (p=-6, step=-2, floor); `done` pulses in the following cycle.
- **Saturation:**
  - Positive: w0=7, delta=-8, x0=7 gives diff 21, so w0=7.
  - Negative: w0=-8, delta=7, x0=7 gives diff -20, so w0=-8.
- **Handshake:**
  - Stimulus: hold `upd_valid`=1 continuously.
  - Required: accepts are exactly 4 cycles apart; `upd_ready`=0 while `busy`; a second update uses weights already rewritten by the first.
- **Load priority:**
  - In IDLE, assert `load_valid` and `upd_valid` together. Required: load is taken, `upd_ready`=0, and no update starts.
  - Assert `load_valid` during UPDATE. Required: it is ignored and the weights follow update arithmetic only.
- **Operand latching:** change `delta` and `inputs` in the cycle after accept. Required: the written weights reflect the values latched at accept.
